// File: rtl/next_pc_gen_pkg.sv
// Shared fetch-unit types: default geometry, PC/PHT-index paths and the next-PC FSM states.
package FetchUnitTypes;

  localparam int unsigned FETCH_WIDTH     = 2;
  localparam int unsigned INSN_BYTE_WIDTH = 4;
  localparam int unsigned PC_WIDTH        = 32;
  localparam int unsigned PHT_ENTRY_NUM   = 2048;
  localparam int unsigned PHT_INDEX_WIDTH = $clog2(PHT_ENTRY_NUM);

  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_1000;

  typedef logic [PC_WIDTH-1:0]        PC_Path;
  typedef logic [PHT_INDEX_WIDTH-1:0] PHT_IndexPath;

  typedef enum logic {
    NPC_INIT,
    NPC_RUN
  } NextPC_State;

endpackage

// File: rtl/next_pc_gen_bp_init_counter.sv
// Wrapping table-index counter for predictor init sweeps; done pulses on the last index.
module bp_init_counter #(
  parameter int unsigned ENTRY_NUM = 2048
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [$clog2(ENTRY_NUM)-1:0] index,
  output logic                         done
);

  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(ENTRY_NUM - 1);

  assign done = en && (index == LAST_INDEX);

  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
    end else if (en) begin
      index <= done ? '0 : index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/next_pc_gen.sv
// Fetch PC register, next-PC priority mux feeding the PHT read index, and predictor-init FSM.
module next_pc_gen
  import FetchUnitTypes::*;
#(
  parameter int unsigned FETCH_WIDTH     = FetchUnitTypes::FETCH_WIDTH,
  parameter int unsigned INSN_BYTE_WIDTH = FetchUnitTypes::INSN_BYTE_WIDTH,
  parameter int unsigned PC_WIDTH        = FetchUnitTypes::PC_WIDTH,
  parameter int unsigned PHT_ENTRY_NUM   = FetchUnitTypes::PHT_ENTRY_NUM,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(FetchUnitTypes::RESET_VECTOR)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic                              clear,
  input  logic                              recover_valid,
  input  logic [PC_WIDTH-1:0]               recover_pc,
  input  logic [FETCH_WIDTH-1:0]            btb_hit,
  input  logic [FETCH_WIDTH-1:0]            pred_taken,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]   btb_target,
  output logic [PC_WIDTH-1:0]               pc_out,
  output logic [PC_WIDTH-1:0]               pred_next_pc,
  output logic                              fetch_valid,
  output logic                              init_busy,
  output logic [$clog2(PHT_ENTRY_NUM)-1:0]  init_index
);

  localparam int unsigned IDX_W = $clog2(PHT_ENTRY_NUM);
  localparam logic [PC_WIDTH-1:0] GROUP_STEP = PC_WIDTH'(FETCH_WIDTH * INSN_BYTE_WIDTH);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(INSN_BYTE_WIDTH - 1));

  NextPC_State state, nextState;

  logic             initEn;
  logic             initDone;
  logic [IDX_W-1:0] sweepIndex;

  logic [PC_WIDTH-1:0] seqPc;
  logic [PC_WIDTH-1:0] takenTarget;
  logic                laneTaken;

  bp_init_counter #(
    .ENTRY_NUM (PHT_ENTRY_NUM)
  ) initCounter (
    .clk   (clk),
    .rst   (rst),
    .en    (initEn),
    .index (sweepIndex),
    .done  (initDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= NPC_INIT;
      pc_out <= RESET_VECTOR;
    end else begin
      state  <= nextState;
      pc_out <= pred_next_pc;
    end
  end

  always_comb begin
    nextState   = state;
    initEn      = 1'b0;
    fetch_valid = 1'b0;
    init_busy   = 1'b0;
    init_index  = '0;
    unique case (state)
      NPC_INIT: begin
        initEn     = 1'b1;
        init_busy  = 1'b1;
        init_index = sweepIndex;
        if (initDone) nextState = NPC_RUN;
      end
      NPC_RUN: begin
        fetch_valid = 1'b1;
      end
      default: nextState = NPC_INIT;
    endcase
  end

  // Lowest taken lane wins; pred_taken alone (no BTB hit) never selects a target.
  always_comb begin
    seqPc       = pc_out + GROUP_STEP;
    laneTaken   = 1'b0;
    takenTarget = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (!laneTaken && btb_hit[i] && pred_taken[i]) begin
        takenTarget = btb_target[i*PC_WIDTH +: PC_WIDTH];
        laneTaken   = 1'b1;
      end
    end
  end

  always_comb begin
    pred_next_pc = seqPc;
    if (state != NPC_RUN) begin
      pred_next_pc = RESET_VECTOR;
    end else if (recover_valid) begin
      pred_next_pc = recover_pc & ALIGN_MASK;
    end else if (stall) begin
      pred_next_pc = pc_out;
    end else if (clear) begin
      pred_next_pc = seqPc;
    end else if (laneTaken) begin
      pred_next_pc = takenTarget & ALIGN_MASK;
    end
  end

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed bench for next_pc_gen with a small init sweep; expected PCs are queued then popped at each edge.
module tb_next_pc_gen;

  localparam int unsigned FW  = 2;
  localparam int unsigned PCW = 32;
  localparam int unsigned PHT = 16;
  localparam int unsigned IW  = $clog2(PHT);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stall = 1'b0;
  logic            clear = 1'b0;
  logic            recover_valid = 1'b0;
  logic [PCW-1:0]  recover_pc = '0;
  logic [FW-1:0]   btb_hit = '0;
  logic [FW-1:0]   pred_taken = '0;
  logic [FW*PCW-1:0] btb_target = '0;
  logic [PCW-1:0]  pc_out;
  logic [PCW-1:0]  pred_next_pc;
  logic            fetch_valid;
  logic            init_busy;
  logic [IW-1:0]   init_index;

  typedef struct {
    string          tag;
    logic [PCW-1:0] exp;
  } ExpEntry;

  ExpEntry sb[$];
  int unsigned passCnt = 0;
  int unsigned checkCnt = 0;

  next_pc_gen #(
    .FETCH_WIDTH     (FW),
    .INSN_BYTE_WIDTH (4),
    .PC_WIDTH        (PCW),
    .PHT_ENTRY_NUM   (PHT),
    .RESET_VECTOR    (32'h0000_1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .clear         (clear),
    .recover_valid (recover_valid),
    .recover_pc    (recover_pc),
    .btb_hit       (btb_hit),
    .pred_taken    (pred_taken),
    .btb_target    (btb_target),
    .pc_out        (pc_out),
    .pred_next_pc  (pred_next_pc),
    .fetch_valid   (fetch_valid),
    .init_busy     (init_busy),
    .init_index    (init_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PCW-1:0] obs, input logic [PCW-1:0] exp);
    checkCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already driven; check the combinational next PC, then the registered PC after the edge.
  task automatic runCycle(input string tag, input logic [PCW-1:0] expNext);
    ExpEntry e;
    sb.push_back('{tag: tag, exp: expNext});
    #1;
    check({tag, "_pred"}, pred_next_pc, expNext);
    tick();
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pc"}, pc_out, e.exp);
    end
  endtask

  task automatic idleInputs();
    stall = 1'b0; clear = 1'b0; recover_valid = 1'b0; recover_pc = '0;
    btb_hit = '0; pred_taken = '0; btb_target = '0;
  endtask

  task automatic checkInitSweep(input string tag);
    for (int unsigned k = 0; k < PHT; k++) begin
      check({tag, "_busy"}, 32'(init_busy), 32'd1);
      check({tag, "_fv"}, 32'(fetch_valid), 32'd0);
      check({tag, "_idx"}, 32'(init_index), k);
      check({tag, "_pc"}, pc_out, 32'h0000_1000);
      tick();
    end
    check({tag, "_run_fv"}, 32'(fetch_valid), 32'd1);
    check({tag, "_run_busy"}, 32'(init_busy), 32'd0);
    check({tag, "_run_idx"}, 32'(init_index), 32'd0);
    check({tag, "_run_pc"}, pc_out, 32'h0000_1000);
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pred", pred_next_pc, 32'h0000_1000);
    checkInitSweep("init");

    runCycle("seq1", 32'h0000_1008);
    runCycle("seq2", 32'h0000_1010);
    stall = 1'b1;
    runCycle("stall1", 32'h0000_1010);
    runCycle("stall2", 32'h0000_1010);
    stall = 1'b0;

    btb_hit = 2'b11; pred_taken = 2'b11; btb_target = {32'h0000_3000, 32'h0000_2000};
    runCycle("lane0", 32'h0000_2000);
    pred_taken = 2'b10;
    runCycle("lane1", 32'h0000_3000);
    btb_hit = 2'b01; pred_taken = 2'b10;
    runCycle("nohit", 32'h0000_3008);
    btb_hit = 2'b01; pred_taken = 2'b01; btb_target = {32'h0000_9000, 32'h0000_5003};
    runCycle("tgtalign", 32'h0000_5000);

    recover_valid = 1'b1; recover_pc = 32'h0000_4002; stall = 1'b1;
    btb_hit = 2'b01; pred_taken = 2'b01; btb_target = {32'h0000_9000, 32'h0000_2000};
    runCycle("recprio", 32'h0000_4000);
    idleInputs();

    recover_valid = 1'b1; recover_pc = 32'hFFFF_FFF8;
    runCycle("recwrap", 32'hFFFF_FFF8);
    recover_valid = 1'b0;
    runCycle("wrap", 32'h0000_0000);
    clear = 1'b1; btb_hit = 2'b01; pred_taken = 2'b01; btb_target = {32'h0000_9000, 32'h0000_2000};
    runCycle("clear", 32'h0000_0008);
    stall = 1'b1;
    runCycle("stallclr", 32'h0000_0008);
    stall = 1'b0;
    recover_valid = 1'b1; recover_pc = 32'h0000_2468;
    runCycle("recclr", 32'h0000_2468);
    idleInputs();
    check("run_fv", 32'(fetch_valid), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    recover_valid = 1'b1; recover_pc = 32'h0000_7000;
    checkInitSweep("reinit");
    recover_valid = 1'b0;
    runCycle("reseq", 32'h0000_1008);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
